// File: rtl/prod_disp_pkg.sv
// Shared types, constants and helpers for the product display block.
package prod_disp_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned SEG_W  = 7;

  typedef enum logic [1:0] {
    LIVE    = 2'd0,
    CAPTURE = 2'd1,
    CONVERT = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // Value as presented on the display: magnitude plus negative marker.
  typedef struct packed {
    logic              neg;
    logic [DATA_W-1:0] mag;
  } conv_t;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Active-low segments, bit 0 = a ... bit 6 = g.
  localparam logic [SEG_W-1:0] HEX_SEG_N [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [SEG_W-1:0] hex_to_seg_n(input logic [NIB_W-1:0] nibble);
    return HEX_SEG_N[nibble];
  endfunction

  // Sign-magnitude conversion; 32'h8000_0000 negates to itself, which is
  // the correct unsigned magnitude.
  function automatic conv_t conv_value(input logic [DATA_W-1:0] value,
                                       input logic              show_mag);
    conv_t r;
    r.neg = show_mag & value[DATA_W-1];
    r.mag = r.neg ? (~value + DATA_W'(1)) : value;
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan.sv
// Multiplexed seven-segment scanner; leading-zero blanking when
// PROD_DISP_BLANK_LEAD_EN is defined.
module seg7_scan
  import prod_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DIGITS      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              dp_en,
  output logic [SEG_W-1:0]  seg_n,
  output logic [DIGITS-1:0] an_n,
  output logic              dp_n
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [NIB_W-1:0] nibble;
  logic             blank;
  logic [SEG_W-1:0] seg_c;

  // Nibble select, optional blanking and decode for the current slot.
  always_comb begin
    nibble = data[{idx, 2'b00} +: NIB_W];
`ifdef PROD_DISP_BLANK_LEAD_EN
    blank  = (idx != '0) && ((data >> {idx, 2'b00}) == '0);
`else
    blank  = 1'b0;
`endif
    seg_c  = blank ? SEG_BLANK : hex_to_seg_n(nibble);
  end

  // Segment data and anode share one edge so no ghosting cycle appears.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= '0;
      seg_n <= SEG_BLANK;
      an_n  <= '1;
      dp_n  <= 1'b1;
    end else begin
      if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
        cnt <= '0;
        idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      an_n  <= ~(DIGITS'(1) << idx);
      seg_n <= seg_c;
      dp_n  <= ~(dp_en && (idx == '0));
    end
  end

endmodule

// File: rtl/product_display.sv
// Captures Booth multiplier products on ready rising edges and shows them in hex.
// Optional leading-zero blanking: define PROD_DISP_BLANK_LEAD_EN.
module product_display
  import prod_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DIGITS      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_ready,
  input  logic [DATA_W-1:0] prod_data,
  input  logic              show_mag,
  input  logic              clear_hold,
  output logic [SEG_W-1:0]  seg_n,
  output logic [DIGITS-1:0] an_n,
  output logic              dp_n,
  output logic              sign_led,
  output logic              held
);

  state_t            state, next_state;
  logic              ready_q;
  logic              rise;
  logic              load_live, load_cap, load_conv;
  logic [DATA_W-1:0] cap_reg, disp_reg, disp_d;
  logic              neg_flag, neg_d;
  conv_t             live_conv, cap_conv;

  assign rise      = prod_ready & ~ready_q;
  assign live_conv = conv_value(prod_data, show_mag);
  assign cap_conv  = conv_value(cap_reg, show_mag);

  always_ff @(posedge clk) begin
    if (rst) state <= LIVE;
    else     state <= next_state;
  end

  // A new rise beats clear_hold when both arrive while holding.
  always_comb begin
    next_state = state;
    unique case (state)
      LIVE:    if (rise) next_state = CAPTURE;
      CAPTURE: next_state = CONVERT;
      CONVERT: next_state = HOLD;
      HOLD: begin
        if (rise)            next_state = CAPTURE;
        else if (clear_hold) next_state = LIVE;
      end
      default: next_state = LIVE;
    endcase
  end

  always_comb begin
    load_live = 1'b0;
    load_cap  = 1'b0;
    load_conv = 1'b0;
    unique case (state)
      LIVE:    load_live = 1'b1;
      CAPTURE: load_cap  = 1'b1;
      CONVERT: load_conv = 1'b1;
      HOLD:    load_live = (next_state == LIVE);
      default: load_live = 1'b1;
    endcase
  end

  always_comb begin
    disp_d = disp_reg;
    neg_d  = neg_flag;
    if (load_live) begin
      disp_d = live_conv.mag;
      neg_d  = live_conv.neg;
    end else if (load_conv) begin
      disp_d = cap_conv.mag;
      neg_d  = cap_conv.neg;
    end
  end

  // Sign LED is dark while a capture is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q  <= 1'b0;
      cap_reg  <= '0;
      disp_reg <= '0;
      neg_flag <= 1'b0;
      held     <= 1'b0;
      sign_led <= 1'b0;
    end else begin
      ready_q  <= prod_ready;
      if (load_cap) cap_reg <= prod_data;
      disp_reg <= disp_d;
      neg_flag <= neg_d;
      held     <= (next_state == HOLD);
      sign_led <= neg_d & ((next_state == HOLD) || (next_state == LIVE));
    end
  end

  seg7_scan #(
    .REFRESH_DIV (REFRESH_DIV),
    .DIGITS      (DIGITS)
  ) u_scan (
    .clk   (clk),
    .rst   (rst),
    .data  (disp_reg),
    .dp_en (held),
    .seg_n (seg_n),
    .an_n  (an_n),
    .dp_n  (dp_n)
  );

endmodule
